// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV64 integer datapath.
// Optional macro PERF_CNT_EN adds retired_cnt_o, a wrapping count of completed instructions.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_en_i,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [1:0]  imm_sel_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        trap_o,
  output logic [2:0]  state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_SB  = 3'd4,
    C_ILL = 3'd5
  } cls_t;

  function automatic logic [1:0] imm_of(input cls_t c);
    case (c)
      C_I, C_LD: imm_of = 2'b00;
      C_ST:      imm_of = 2'b01;
      C_SB:      imm_of = 2'b11;
      default:   imm_of = 2'b10;
    endcase
  endfunction

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, cls_dec;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout;
  logic             end_instr;

  logic             mem_read_q, mem_write_q, alu_src_q, pc_write_cond_q;
  logic             reg_write_q, mem_to_reg_q, trap_q;
  logic [1:0]       alu_op_q, imm_sel_q;
`ifdef PERF_CNT_EN
  logic [31:0]      retired_q;
`endif

  always_comb begin
    case (opcode_i)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LD;
      7'b0100011: cls_dec = C_ST;
      7'b1100011: cls_dec = C_SB;
      default:    cls_dec = C_ILL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    end_instr = 1'b0;
    wait_d    = wait_q;
    // A ready arriving on the limit cycle still wins over the timeout.
    timeout   = (wait_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready_i;

    unique case (state_q)
      S_IDLE: if (run_en_i) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        state_d = (cls_dec == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_R, C_I:  state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          default:   end_instr = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i) begin
          if (cls_q == C_LD) state_d = S_WB;
          else               end_instr = 1'b1;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB:    end_instr = 1'b1;
      default: state_d = S_TRAP;
    endcase

    if (end_instr) state_d = run_en_i ? S_FETCH : S_IDLE;

    if ((state_d == S_FETCH && state_q != S_FETCH) ||
        (state_d == S_MEM && state_q != S_MEM)) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready_i) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      cls_q           <= C_R;
      wait_q          <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      alu_src_q       <= 1'b0;
      alu_op_q        <= 2'b00;
      pc_write_cond_q <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      imm_sel_q       <= 2'b10;
      trap_q          <= 1'b0;
`ifdef PERF_CNT_EN
      retired_q       <= 32'd0;
`endif
    end else begin
      state_q         <= state_d;
      cls_q           <= cls_d;
      wait_q          <= wait_d;
      mem_read_q      <= (state_d == S_FETCH) || (state_d == S_MEM && cls_d == C_LD);
      mem_write_q     <= (state_d == S_MEM) && (cls_d == C_ST);
      alu_src_q       <= (state_d == S_EXEC) && (cls_d inside {C_I, C_LD, C_ST});
      pc_write_cond_q <= (state_d == S_EXEC) && (cls_d == C_SB);
      reg_write_q     <= (state_d == S_WB);
      mem_to_reg_q    <= (state_d == S_WB) && (cls_d == C_LD);
      trap_q          <= (state_d == S_TRAP);
      if (state_d == S_EXEC) begin
        case (cls_d)
          C_R, C_I: alu_op_q <= 2'b10;
          C_SB:     alu_op_q <= 2'b01;
          default:  alu_op_q <= 2'b00;
        endcase
      end else begin
        alu_op_q <= 2'b00;
      end
      if (state_d inside {S_EXEC, S_MEM, S_WB}) imm_sel_q <= imm_of(cls_d);
      else                                      imm_sel_q <= 2'b10;
`ifdef PERF_CNT_EN
      if (end_instr) retired_q <= retired_q + 32'd1;
`endif
    end
  end

  // In DECODE the class is not latched yet, so imm_sel comes straight from the opcode.
  assign imm_sel_o       = (state_q == S_DECODE) ? imm_of(cls_dec) : imm_sel_q;
  assign ir_write_o      = (state_q == S_FETCH) && mem_ready_i;
  assign pc_write_o      = (state_q == S_FETCH) && mem_ready_i;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign alu_src_o       = alu_src_q;
  assign alu_op_o        = alu_op_q;
  assign pc_write_cond_o = pc_write_cond_q;
  assign reg_write_o     = reg_write_q;
  assign mem_to_reg_o    = mem_to_reg_q;
  assign trap_o          = trap_q;
  assign state_o         = state_q;
`ifdef PERF_CNT_EN
  assign retired_cnt_o   = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class and the memory timeout paths.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset, run_en, mem_ready;
  logic [6:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic [1:0] imm_sel, alu_op;
  logic       alu_src, reg_write, mem_to_reg, trap;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_SB  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_en_i        (run_en),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .ir_write_o      (ir_write),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .imm_sel_o       (imm_sel),
    .alu_src_o       (alu_src),
    .alu_op_o        (alu_op),
    .reg_write_o     (reg_write),
    .mem_to_reg_o    (mem_to_reg),
    .trap_o          (trap),
    .state_o         (state)
`ifdef PERF_CNT_EN
    ,
    .retired_cnt_o   (retired_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; run_en = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({mem_read, mem_write, reg_write, mem_to_reg, trap, pc_write_cond, alu_src, ir_write, pc_write} !== 9'd0)
      begin n_bad++; $display("FAIL reset_strobes: got %b want 0", {mem_read, mem_write, reg_write, mem_to_reg, trap, pc_write_cond, alu_src, ir_write, pc_write}); end
    n_cmp++; if ({imm_sel, alu_op} !== 4'b1000) begin n_bad++; $display("FAIL reset_imm_alu: got %b want 1000", {imm_sel, alu_op}); end
`ifdef PERF_CNT_EN
    n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
`endif
  endtask

  task automatic test_r_type();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    tick();
    n_cmp++; if ({state, ir_write, pc_write, mem_read} !== {3'd1, 3'b111}) begin n_bad++; $display("FAIL r_fetch: got %b want 001111", {state, ir_write, pc_write, mem_read}); end
    tick();
    n_cmp++; if ({state, reg_write, mem_read} !== {3'd2, 2'b00}) begin n_bad++; $display("FAIL r_decode: got %b want 01000", {state, reg_write, mem_read}); end
    tick();
    n_cmp++; if ({state, alu_src, alu_op, imm_sel, reg_write} !== {3'd3, 1'b0, 2'b10, 2'b10, 1'b0}) begin n_bad++; $display("FAIL r_exec: got %b want 011010100", {state, alu_src, alu_op, imm_sel, reg_write}); end
    tick();
    n_cmp++; if ({state, reg_write, mem_to_reg, imm_sel} !== {3'd5, 1'b1, 1'b0, 2'b10}) begin n_bad++; $display("FAIL r_wb: got %b want 10110010", {state, reg_write, mem_to_reg, imm_sel}); end
    tick();
    n_cmp++; if ({state, reg_write} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL r_next_fetch: got %b want 0010", {state, reg_write}); end
    // Reset lands while FETCH is strobing memory.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({state, mem_read, ir_write, pc_write} !== {3'd0, 3'b000}) begin n_bad++; $display("FAIL reset_abort: got %b want 000000", {state, mem_read, ir_write, pc_write}); end
  endtask

  task automatic test_load();
    int cyc = 0, memc = 0, rdc = 0;
    logic [1:0] wb_flags = 2'b00;
    logic [2:0] exec_bits = 3'b111;
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_LD;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 3'd0) break;
      cyc++;
      if (state == 3'd3) exec_bits = {alu_src, alu_op};
      if (state == 3'd4) begin
        memc++;
        rdc += int'(mem_read);
        mem_ready = (memc >= 4);
      end else begin
        mem_ready = 1'b1;
      end
      if (state == 3'd5) begin
        wb_flags = {reg_write, mem_to_reg};
        run_en   = 1'b0;
      end
    end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL ld_cycles: got %0d want 8", cyc); end
    n_cmp++; if (rdc !== 4) begin n_bad++; $display("FAIL ld_mem_read_cycles: got %0d want 4", rdc); end
    n_cmp++; if (exec_bits !== 3'b100) begin n_bad++; $display("FAIL ld_exec_alu: got %b want 100", exec_bits); end
    n_cmp++; if (wb_flags !== 2'b11) begin n_bad++; $display("FAIL ld_wb_flags: got %b want 11", wb_flags); end
  endtask

  task automatic test_store_branch();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_ST;
    tick(); tick(); tick();
    n_cmp++; if ({state, imm_sel, alu_src, alu_op} !== {3'd3, 2'b01, 1'b1, 2'b00}) begin n_bad++; $display("FAIL st_exec: got %b want 01101100", {state, imm_sel, alu_src, alu_op}); end
    tick();
    n_cmp++; if ({state, mem_write, mem_read, imm_sel} !== {3'd4, 1'b1, 1'b0, 2'b01}) begin n_bad++; $display("FAIL st_mem: got %b want 1001001", {state, mem_write, mem_read, imm_sel}); end
    opcode = OP_SB;
    tick();
    n_cmp++; if ({state, mem_write} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL st_write_one_cycle: got %b want 0010", {state, mem_write}); end
    tick();
    n_cmp++; if ({state, imm_sel} !== {3'd2, 2'b11}) begin n_bad++; $display("FAIL sb_decode_imm: got %b want 01011", {state, imm_sel}); end
    tick();
    n_cmp++; if ({state, pc_write_cond, imm_sel, alu_src, alu_op} !== {3'd3, 1'b1, 2'b11, 1'b0, 2'b01}) begin n_bad++; $display("FAIL sb_exec: got %b want 011111001", {state, pc_write_cond, imm_sel, alu_src, alu_op}); end
    run_en = 1'b0;
    tick();
    n_cmp++; if ({state, pc_write_cond} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL sb_end_idle: got %b want 0000", {state, pc_write_cond}); end
  endtask

  task automatic test_illegal();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_BAD;
    tick(); tick(); tick();
    n_cmp++; if ({state, trap, mem_read} !== {3'd6, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ill_trap: got %b want 11010", {state, trap, mem_read}); end
    tick(); tick(); tick();
    n_cmp++; if ({state, trap, mem_read, ir_write} !== {3'd6, 3'b100}) begin n_bad++; $display("FAIL ill_sticky: got %b want 110100", {state, trap, mem_read, ir_write}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({state, trap} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL ill_reset_clear: got %b want 0000", {state, trap}); end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b0;
    tick();
    n_cmp++; if ({state, ir_write, pc_write} !== {3'd1, 2'b00}) begin n_bad++; $display("FAIL to_fetch_no_ready: got %b want 00100", {state, ir_write, pc_write}); end
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if ({state, mem_read} !== {3'd1, 1'b1}) begin n_bad++; $display("FAIL to_fetch_at_limit: got %b want 0011", {state, mem_read}); end
    tick();
    n_cmp++; if ({state, trap, mem_read} !== {3'd6, 2'b10}) begin n_bad++; $display("FAIL to_fetch_trap: got %b want 11010", {state, trap, mem_read}); end
  endtask

  task automatic test_fetch_ready_at_limit();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    #1;
    n_cmp++; if ({state, ir_write, pc_write} !== {3'd1, 2'b11}) begin n_bad++; $display("FAIL lim_ready_strobes: got %b want 00111", {state, ir_write, pc_write}); end
    tick();
    n_cmp++; if ({state, trap} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL lim_ready_advance: got %b want 0100", {state, trap}); end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_ST;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if ({state, mem_write} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL mem_to_at_limit: got %b want 1001", {state, mem_write}); end
    tick();
    n_cmp++; if ({state, trap, mem_write} !== {3'd6, 2'b10}) begin n_bad++; $display("FAIL mem_to_trap: got %b want 11010", {state, trap, mem_write}); end
  endtask

  task automatic test_run_en_drop();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    tick();
    run_en = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if ({state, reg_write} !== {3'd5, 1'b1}) begin n_bad++; $display("FAIL drop_finishes_wb: got %b want 1011", {state, reg_write}); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL drop_idle: got %0d want 0", state); end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    run_en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 40) run_en = 1'b0;
    end
    tick();
    n_cmp++; if ({state, retired_cnt} !== {3'd0, 32'd10}) begin n_bad++; $display("FAIL perf_ten_r: got state %0d cnt %0d want 0 10", state, retired_cnt); end
    run_en = 1'b1; opcode = OP_BAD;
    tick(); tick(); tick(); tick();
    n_cmp++; if ({state, retired_cnt} !== {3'd6, 32'd10}) begin n_bad++; $display("FAIL perf_trap_not_counted: got state %0d cnt %0d want 6 10", state, retired_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; run_en = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    test_reset();
    test_r_type();
    test_load();
    test_store_branch();
    test_illegal();
    test_fetch_timeout();
    test_fetch_ready_at_limit();
    test_mem_timeout();
    test_run_en_drop();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
